// File: rtl/cr_kme_kop_keybuilder_rx.sv
// cr_kme_kop_keybuilder_rx: assembles KDF stream words into one wide key per command.
// Optional KME_KEYBUILDER_ZEROIZE_EN wipes the key register after each key handshake.
module cr_kme_kop_keybuilder_rx #(
    parameter int WORD_W    = 64,
    parameter int MAX_WORDS = 8,
    parameter int NW_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmdfifo_keybuilder_valid,
    input  logic [NW_W-1:0]             cmdfifo_keybuilder_num_words,
    output logic                        keybuilder_cmdfifo_ack,
    input  logic [WORD_W-1:0]           kdf_keybuilder_data,
    input  logic                        kdf_keybuilder_valid,
    output logic                        keybuilder_kdf_stall,
    output logic [MAX_WORDS*WORD_W-1:0] keybuilder_key_data,
    output logic [NW_W-1:0]             keybuilder_key_num_words,
    output logic                        keybuilder_key_valid,
    input  logic                        key_keybuilder_ack,
    output logic                        keybuilder_err
);
    localparam int KEY_W = MAX_WORDS * WORD_W;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [NW_W-1:0]    cnt_q, cnt_d;
    logic [NW_W-1:0]    n_q, n_d;
    logic               err_q, err_d;
    logic               legal;
    logic               xfer;

    assign legal = (cmdfifo_keybuilder_num_words != '0) &&
                   (cmdfifo_keybuilder_num_words <= NW_W'(MAX_WORDS));
    assign xfer  = kdf_keybuilder_valid && (state_q == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        err_d   = err_q;
        keybuilder_cmdfifo_ack   = (state_q == IDLE) && cmdfifo_keybuilder_valid;
        keybuilder_kdf_stall     = (state_q != COLLECT);
        keybuilder_key_valid     = (state_q == HOLD);
        keybuilder_key_num_words = (state_q == HOLD) ? n_q : '0;
        keybuilder_err           = err_q;
        case (state_q)
            IDLE: begin
                if (cmdfifo_keybuilder_valid) begin
                    if (legal) begin
                        n_d     = cmdfifo_keybuilder_num_words;
                        key_d   = '0;
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    // first word lands in the most significant slot
                    for (int i = 0; i < MAX_WORDS; i++)
                        if (cnt_q == NW_W'(i))
                            key_d[(MAX_WORDS-1-i)*WORD_W +: WORD_W] = kdf_keybuilder_data;
                    cnt_d = cnt_q + NW_W'(1);
                    if (cnt_q == n_q - NW_W'(1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (key_keybuilder_ack) begin
                    state_d = IDLE;
`ifdef KME_KEYBUILDER_ZEROIZE_EN
                    key_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KME_KEYBUILDER_ZEROIZE_EN
    assign keybuilder_key_data = (state_q == HOLD) ? key_q : '0;
`else
    assign keybuilder_key_data = key_q;
`endif

endmodule

// File: tb/tb_cr_kme_kop_keybuilder_rx.sv
// tb_cr_kme_kop_keybuilder_rx: table-driven commands plus hand sequences for reset and IDLE streaming.
module tb_cr_kme_kop_keybuilder_rx;
    localparam int WW = 64, MW = 8, NW = 4, KW = MW * WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_v = 1'b0;
    logic [NW-1:0] cmd_nw = '0;
    logic          cmd_ack;
    logic [WW-1:0] kd = '0;
    logic          kv = 1'b0;
    logic          stall;
    logic [KW-1:0] key;
    logic [NW-1:0] key_nw;
    logic          key_v;
    logic          kack = 1'b0;
    logic          err;

    int errs = 0, checks = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    cr_kme_kop_keybuilder_rx dut (
        .clk(clk), .rst_n(rst_n),
        .cmdfifo_keybuilder_valid(cmd_v), .cmdfifo_keybuilder_num_words(cmd_nw),
        .keybuilder_cmdfifo_ack(cmd_ack),
        .kdf_keybuilder_data(kd), .kdf_keybuilder_valid(kv), .keybuilder_kdf_stall(stall),
        .keybuilder_key_data(key), .keybuilder_key_num_words(key_nw),
        .keybuilder_key_valid(key_v), .key_keybuilder_ack(kack), .keybuilder_err(err)
    );

    typedef struct {
        int         nw;
        logic [7:0] tag;
        int         hold;
        bit         rnd;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] wd(input logic [7:0] tag, input int k);
        logic [7:0] b;
        b = tag + 8'(17 * k);
        return {8{b}};
    endfunction

    function automatic logic [KW-1:0] model(input int nw, input logic [7:0] tag);
        logic [KW-1:0] m;
        m = '0;
        for (int i = 0; i < nw; i++) m[(MW-1-i)*WW +: WW] = wd(tag, i);
        return m;
    endfunction

    task automatic cmd(input int nw, input bit legal);
        cmd_v  = 1'b1;
        cmd_nw = NW'(nw);
        #1;
        chk("cmd_ack", KW'(cmd_ack), KW'(1));
        tick();
        cmd_v = 1'b0;
        if (!legal) exp_err = 1'b1;
        #1;
        chk("cmd_ack_single", KW'(cmd_ack), KW'(0));
        chk("err", KW'(err), KW'(exp_err));
        chk("stall_after_cmd", KW'(stall), KW'(!legal));
        chk("valid_after_cmd", KW'(key_v), KW'(0));
    endtask

    task automatic words(input int nw, input logic [7:0] tag, input bit rnd);
        int k = 0, guard = 0;
        while (k < nw && guard < 200) begin
            kv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            kd = kv ? wd(tag, k) : {WW{1'b1}};
            #1;
            chk("stall_collect", KW'(stall), KW'(0));
            chk("valid_collect", KW'(key_v), KW'(0));
            if (kv) k++;
            tick();
            guard++;
        end
        kv = 1'b0;
        if (guard >= 200) begin
            errs++;
            $display("FAIL words_timeout: sent %0d required %0d", k, nw);
        end
    endtask

    task automatic hold_ack(input int nw, input logic [7:0] tag, input int hold);
        logic [KW-1:0] e;
        e = model(nw, tag);
        #1;
        chk("key_valid", KW'(key_v), KW'(1));
        chk("key_nw", KW'(key_nw), KW'(nw));
        chk("key_data", key, e);
        chk("stall_hold", KW'(stall), KW'(1));
        for (int i = 0; i < hold; i++) begin
            cmd_v = 1'b1;
            #1;
            chk("no_cmd_ack_hold", KW'(cmd_ack), KW'(0));
            tick();
            cmd_v = 1'b0;
            kv = 1'b1;
            kd = {WW{1'b1}};
            #1;
            chk("stall_hold", KW'(stall), KW'(1));
            chk("valid_hold", KW'(key_v), KW'(1));
            chk("key_stable", key, e);
            kv = 1'b0;
        end
        kack = 1'b1;
        tick();
        kack = 1'b0;
        #1;
        chk("valid_after_ack", KW'(key_v), KW'(0));
        chk("stall_after_ack", KW'(stall), KW'(1));
        chk("nw_after_ack", KW'(key_nw), KW'(0));
`ifdef KME_KEYBUILDER_ZEROIZE_EN
        chk("key_after_ack", key, '0);
`else
        chk("key_after_ack", key, e);
`endif
    endtask

    initial begin
        tbl[0] = '{4, 8'h11, 0, 1'b0};
        tbl[1] = '{8, 8'h01, 10, 1'b1};
        tbl[2] = '{0, 8'h00, 0, 1'b0};
        tbl[3] = '{9, 8'h00, 0, 1'b0};
        tbl[4] = '{1, 8'hA5, 2, 1'b0};
        tbl[5] = '{2, 8'h3C, 0, 1'b0};

        #12;
        chk("rst_stall", KW'(stall), KW'(1));
        chk("rst_valid", KW'(key_v), KW'(0));
        chk("rst_nw", KW'(key_nw), KW'(0));
        chk("rst_err", KW'(err), KW'(0));
        chk("rst_cmd_ack", KW'(cmd_ack), KW'(0));
        chk("rst_key", key, '0);
        rst_n = 1'b1;
        tick();

        chk("words_4_layout_hi", model(4, 8'h11) >> 256,
            KW'(256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444));
        chk("words_4_layout_lo", KW'(model(4, 8'h11) & {256'b0, {256{1'b1}}}), '0);

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].nw >= 1 && tbl[v].nw <= MW) begin
                cmd(tbl[v].nw, 1'b1);
                words(tbl[v].nw, tbl[v].tag, tbl[v].rnd);
                hold_ack(tbl[v].nw, tbl[v].tag, tbl[v].hold);
            end else begin
                cmd(tbl[v].nw, 1'b0);
            end
        end

        kv = 1'b1;
        kd = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_idle_stream", KW'(stall), KW'(1));
            tick();
        end
        cmd(1, 1'b1);
        tick();
        kv = 1'b0;
        #1;
        chk("dead_valid", KW'(key_v), KW'(1));
        chk("dead_key", key, {64'hDEAD_BEEF_DEAD_BEEF, 448'b0});
        kack = 1'b1;
        tick();
        kack = 1'b0;
        #1;
        chk("dead_idle", KW'(key_v), KW'(0));

        cmd(6, 1'b1);
        words(3, 8'h70, 1'b0);
        #1;
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("midrst_valid", KW'(key_v), KW'(0));
        chk("midrst_stall", KW'(stall), KW'(1));
        chk("midrst_err", KW'(err), KW'(0));
        chk("midrst_key", key, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        chk("postrst_stall", KW'(stall), KW'(1));
        cmd(2, 1'b1);
        words(2, 8'h09, 1'b0);
        hold_ack(2, 8'h09, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end
endmodule
